// File: rtl/wb_bfm_params.sv
// Shared Wishbone bus-cycle encodings (CTI cycle types, BTE burst types).
// Any block that decodes or drives registered-feedback bursts takes its
// encodings from here so that masters, slaves and BFMs stay in agreement.
package wb_bfm_params;

   localparam logic [2:0] CTI_CLASSIC      = 3'b000;
   localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
   localparam logic [2:0] CTI_INC_BURST    = 3'b010;
   localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP_4  = 2'b01;
   localparam logic [1:0] BTE_WRAP_8  = 2'b10;
   localparam logic [1:0] BTE_WRAP_16 = 2'b11;

endpackage

// File: rtl/wb_burst_ram_pkg.sv
// Local types and helpers for wb_burst_ram.
//   state_t     : slave FSM states (IDLE, BURST)
//   cti_streams : 1 when a cycle type keeps the slave in streaming mode
//   wrap_mask   : low word-address bits that wrap for a given BTE
package wb_burst_ram_pkg;
   import wb_bfm_params::*;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   function automatic logic cti_streams(input logic [2:0] cti);
      return (cti == CTI_CONST_BURST) || (cti == CTI_INC_BURST);
   endfunction

   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      logic [3:0] m;
      case (bte)
         BTE_WRAP_4:  m = 4'h3;
         BTE_WRAP_8:  m = 4'h7;
         BTE_WRAP_16: m = 4'hF;
         default:     m = 4'h0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Predicts the word address of the next beat of a Wishbone burst.
// Ports:
//   adr     in  WAW  current word address
//   cti     in  3    cycle type of the current beat
//   bte     in  2    burst type of the current beat
//   nxt_adr out WAW  predicted word address of the following beat
// Constant bursts repeat the address; incrementing bursts either count
// linearly (wrapping at 2^WAW) or count inside a 4/8/16-word window.
module wb_burst_adr_gen
   import wb_bfm_params::*;
   import wb_burst_ram_pkg::*;
#(
   parameter int WAW = 30
) (
   input  logic [WAW-1:0] adr,
   input  logic [2:0]     cti,
   input  logic [1:0]     bte,
   output logic [WAW-1:0] nxt_adr
);

   logic [WAW-1:0] inc;
   logic [WAW-1:0] mask;

   always_comb begin
      inc     = adr + 1'b1;
      mask    = WAW'(wrap_mask(bte));
      nxt_adr = adr;
      if (cti == CTI_INC_BURST) begin
         if (bte == BTE_LINEAR)
            nxt_adr = inc;
         else
            // carry out of the window is discarded, upper bits stay put
            nxt_adr = (adr & ~mask) | (inc & mask);
      end
   end

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone slave RAM with registered-feedback burst support.
// Ports:
//   wb_clk_i  in   1   clock (rising edge)
//   wb_rst_i  in   1   synchronous reset, active low
//   wb_adr_i  in   aw  byte address, word index = wb_adr_i[aw-1:2]
//   wb_dat_i  in   dw  write data
//   wb_sel_i  in   4   byte-lane write enables
//   wb_we_i, wb_cyc_i, wb_stb_i  in  1  write enable, cycle, strobe
//   wb_cti_i  in   3   cycle type
//   wb_bte_i  in   2   burst type
//   wb_sdt_o  out  dw  read data, zero unless wb_ack_o
//   wb_ack_o, wb_err_o, wb_rty_o  out 1  ack, error, retry (tied 0)
// A beat is answered one cycle later. In IDLE a beat that is already being
// answered is not taken again, giving classic single-wait-state cycles.
// A burst cycle type moves to BURST, where every strobed cycle whose address
// matches the prediction is a new beat, so acks stream back to back.
module wb_burst_ram
   import wb_bfm_params::*;
   import wb_burst_ram_pkg::*;
#(
   parameter int    aw      = 32,
   parameter int    dw      = 32,
   parameter int    DEPTH   = 1024,
   parameter string MEMFILE = ""
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [aw-1:0] wb_adr_i,
   input  logic [dw-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [dw-1:0] wb_sdt_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o
);

   localparam int WAW = aw - 2;
   localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW  = dw / 4;

   logic [dw-1:0]  mem [DEPTH];

   state_t         state_q, state_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;
   logic           rvld_q, rvld_d;
   logic [WAW-1:0] pred_q, pred_d;
   logic [WAW-1:0] widx, nxt_adr;
   logic [MAW-1:0] ridx;
   logic [dw-1:0]  rd_q;
   logic           take, in_range, wr_en;
   logic           unused_adr;

   assign widx       = wb_adr_i[aw-1:2];
   assign ridx       = widx[MAW-1:0];
   assign in_range   = {{(64-WAW){1'b0}}, widx} < 64'(DEPTH);
   assign unused_adr = ^wb_adr_i[1:0];

   wb_burst_adr_gen #(.WAW(WAW)) u_adr_gen (
      .adr     (widx),
      .cti     (wb_cti_i),
      .bte     (wb_bte_i),
      .nxt_adr (nxt_adr)
   );

   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rvld_d  = 1'b0;
      take    = 1'b0;
      if (!wb_cyc_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  take = wb_stb_i && !ack_q && !err_q;
            ST_BURST: begin
               if (wb_stb_i) begin
                  if (widx == pred_q)
                     take = 1'b1;
                  else
                     // off-prediction: skip a cycle and let IDLE pick it up
                     state_d = ST_IDLE;
               end
            end
            default:  state_d = ST_IDLE;
         endcase
         if (take) begin
            if (!in_range) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ack_d  = 1'b1;
               rvld_d = !wb_we_i;
               if (cti_streams(wb_cti_i)) begin
                  state_d = ST_BURST;
                  pred_d  = nxt_adr;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      end
   end

   // reset also blocks the write of a beat caught by the reset edge
   assign wr_en = ack_d && wb_we_i && wb_rst_i;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rvld_q  <= 1'b0;
         pred_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rvld_q  <= rvld_d;
         pred_q  <= pred_d;
      end
   end

   // memory is never cleared by reset
   always_ff @(posedge wb_clk_i) begin
      for (int l = 0; l < 4; l++)
         if (wr_en && wb_sel_i[l])
            mem[ridx][l*LW +: LW] <= wb_dat_i[l*LW +: LW];
      if (rvld_d)
         rd_q <= mem[ridx];
   end

   assign wb_sdt_o = rvld_q ? rd_q : '0;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram. A byte-lane memory model plus per-cycle
// expected responses are produced by the stimulus tasks; one process compares
// the bus outputs against them on every falling edge.
module tb_wb_burst_ram;
   import wb_bfm_params::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dat = '0;
   logic [3:0]  sel = '0;
   logic [2:0]  cti = CTI_CLASSIC;
   logic [1:0]  bte = BTE_LINEAR;
   logic [31:0] sdt;
   logic        ack, err, rty;

   int          total = 0, bad = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] rd_log [$];
   logic [31:0] adr_log [$];
   bit          chk_on = 1'b0, exp_ack = 1'b0, exp_err = 1'b0, exp_rd = 1'b0;
   logic [31:0] exp_dat = '0;

   always #5 clk = ~clk;

   wb_burst_ram #(.aw(32), .dw(32), .DEPTH(DEPTH), .MEMFILE("")) dut (
      .wb_clk_i (clk),   .wb_rst_i (rst_n), .wb_adr_i (adr), .wb_dat_i (dat),
      .wb_sel_i (sel),   .wb_we_i  (we),    .wb_cyc_i (cyc), .wb_stb_i (stb),
      .wb_cti_i (cti),   .wb_bte_i (bte),   .wb_sdt_o (sdt), .wb_ack_o (ack),
      .wb_err_o (err),   .wb_rty_o (rty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ack", 32'(ack), 32'(exp_ack));
         chk("err", 32'(err), 32'(exp_err));
         chk("rty", 32'(rty), 32'h0);
         if (exp_ack && exp_rd) chk("rdata", sdt, exp_dat);
         else if (!exp_ack)     chk("sdt_idle_zero", sdt, 32'h0);
         if (ack && exp_rd) rd_log.push_back(sdt);
      end
   end

   // advance one cycle; the arguments are what the bus must show after the edge
   task automatic step(input bit a, input bit e, input bit r, input logic [31:0] d);
      @(posedge clk); #1;
      exp_ack = a; exp_err = e; exp_rd = r; exp_dat = d;
   endtask

   task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int l = 0; l < 4; l++)
         if (s[l]) model[a[11:2]][l*8 +: 8] = d[l*8 +: 8];
   endtask

   task automatic beat(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] t);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = t;
   endtask

   task automatic release_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
   endtask

   // byte-address arithmetic for the next beat of a burst
   function automatic logic [31:0] next_byte_adr(input logic [31:0] a, input logic [2:0] t,
                                                 input logic [1:0] b);
      logic [31:0] span;
      if (t == CTI_CONST_BURST) return a;
      if (b == BTE_LINEAR) return a + 32'd4;
      span = 32'd8 << b;
      return (a / span) * span + ((a + 32'd4) % span);
   endfunction

   task automatic classic_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      beat(1'b1, a, d, s, CTI_CLASSIC);
      step(1, 0, 0, 0); mwrite(a, d, s);
      step(0, 0, 0, 0);                      // strobe still held: no second ack
      release_bus();
   endtask

   task automatic classic_rd(input logic [31:0] a);
      beat(1'b0, a, 32'h0, 4'h0, CTI_CLASSIC);
      step(1, 0, 1, model[a[11:2]]);
      step(0, 0, 0, 0);
      release_bus();
   endtask

   task automatic burst(input bit w, input logic [31:0] base, input int n,
                        input logic [2:0] t, input logic [1:0] b, input logic [31:0] d0);
      logic [31:0] a;
      a = base;
      adr_log.delete();
      for (int i = 0; i < n; i++) begin
         beat(w, a, d0 + 32'(i), 4'hF, (i == n - 1) ? CTI_END_OF_BURST : t);
         bte = b;
         adr_log.push_back(a);
         if (w) begin step(1, 0, 0, 0); mwrite(a, d0 + 32'(i), 4'hF); end
         else   step(1, 0, 1, model[a[11:2]]);
         a = next_byte_adr(a, t, b);
      end
      release_bus();
      step(0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got still running want finished");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1; chk_on = 1'b1;                     // outputs under reset must be 0
      step(0, 0, 0, 0);
      rst_n = 1'b1;
      step(0, 0, 0, 0);

      // classic write/read
      classic_wr(32'h10, 32'hDEADBEEF, 4'hF);
      rd_log.delete(); classic_rd(32'h10);
      chk("classic_lit", rd_log[0], 32'hDEADBEEF);

      // incrementing linear 8-beat write then read
      burst(1'b1, 32'h20, 8, CTI_INC_BURST, BTE_LINEAR, 32'hA000_0000);
      rd_log.delete();
      burst(1'b0, 32'h20, 8, CTI_INC_BURST, BTE_LINEAR, 32'h0);
      chk("lin_count", 32'(rd_log.size()), 32'd8);
      chk("lin_first", rd_log[0], 32'hA000_0000);
      chk("lin_last",  rd_log[7], 32'hA000_0007);

      // wrap-4 read from 0x38
      rd_log.delete();
      burst(1'b0, 32'h38, 4, CTI_INC_BURST, BTE_WRAP_4, 32'h0);
      chk("wrap_adr2", adr_log[2], 32'h30);
      chk("wrap_adr3", adr_log[3], 32'h34);
      chk("wrap_d0", rd_log[0], 32'hA000_0006);
      chk("wrap_d1", rd_log[1], 32'hA000_0007);
      chk("wrap_d2", rd_log[2], 32'hA000_0004);
      chk("wrap_d3", rd_log[3], 32'hA000_0005);

      // constant-address burst
      rd_log.delete();
      burst(1'b0, 32'h10, 3, CTI_CONST_BURST, BTE_LINEAR, 32'h0);
      chk("const_d2", rd_log[2], 32'hDEADBEEF);

      // byte-lane merge
      classic_wr(32'h40, 32'hFFFF_FFFF, 4'hF);
      classic_wr(32'h40, 32'h1122_3344, 4'b0101);
      rd_log.delete(); classic_rd(32'h40);
      chk("sel_merge", rd_log[0], 32'hFF22_FF44);

      // burst with a 2-cycle strobe gap, then cycle dropped after beat 4
      beat(1'b1, 32'h20, 32'hB000_0000, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'h20, 32'hB000_0000, 4'hF);
      beat(1'b1, 32'h24, 32'hB000_0001, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'h24, 32'hB000_0001, 4'hF);
      stb = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      beat(1'b1, 32'h28, 32'hB000_0002, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'h28, 32'hB000_0002, 4'hF);
      beat(1'b1, 32'h2C, 32'hB000_0003, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'h2C, 32'hB000_0003, 4'hF);
      release_bus();
      step(0, 0, 0, 0);
      rd_log.delete();
      classic_rd(32'h2C);
      classic_rd(32'h30);
      chk("gap_beat4", rd_log[0], 32'hB000_0003);
      chk("gap_no_beat5", rd_log[1], 32'hA000_0004);

      // address off prediction mid-burst: one dead cycle then restart
      rd_log.delete();
      beat(1'b0, 32'h20, 32'h0, 4'hF, CTI_INC_BURST);
      step(1, 0, 1, model[8]);
      beat(1'b0, 32'h30, 32'h0, 4'hF, CTI_END_OF_BURST);
      step(0, 0, 0, 0);
      step(1, 0, 1, model[12]);
      release_bus();
      step(0, 0, 0, 0);
      chk("restart_d", rd_log[1], 32'hA000_0004);

      // out-of-range: classic read and burst running past the end
      classic_wr(32'h0, 32'h0BAD_F00D, 4'hF);
      beat(1'b0, 32'h1000, 32'h0, 4'hF, CTI_CLASSIC);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      release_bus();
      beat(1'b1, 32'hFF8, 32'hC000_0000, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'hFF8, 32'hC000_0000, 4'hF);
      beat(1'b1, 32'hFFC, 32'hC000_0001, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'hFFC, 32'hC000_0001, 4'hF);
      beat(1'b1, 32'h1000, 32'hC000_0002, 4'hF, CTI_INC_BURST);
      step(0, 1, 0, 0);
      release_bus();
      step(0, 0, 0, 0);
      rd_log.delete();
      classic_rd(32'h0);
      classic_rd(32'hFFC);
      chk("err_no_alias", rd_log[0], 32'h0BAD_F00D);
      chk("err_prior_ok", rd_log[1], 32'hC000_0001);

      // reset during a burst: no ack, no write, memory kept
      classic_wr(32'h54, 32'h5454_5454, 4'hF);
      beat(1'b1, 32'h50, 32'hD000_0000, 4'hF, CTI_INC_BURST);
      step(1, 0, 0, 0); mwrite(32'h50, 32'hD000_0000, 4'hF);
      beat(1'b1, 32'h54, 32'hD000_0001, 4'hF, CTI_INC_BURST);
      rst_n = 1'b0;
      step(0, 0, 0, 0);
      rst_n = 1'b1;
      release_bus();
      step(0, 0, 0, 0);
      rd_log.delete();
      classic_rd(32'h54);
      classic_rd(32'h50);
      classic_rd(32'h24);
      chk("rst_no_write", rd_log[0], 32'h5454_5454);
      chk("rst_prior_beat", rd_log[1], 32'hD000_0000);
      chk("rst_mem_kept", rd_log[2], 32'hB000_0001);

      step(0, 0, 0, 0);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_burst_ram.md
WB_BURST_RAM -- requirements
Module: wb_burst_ram

Interface
REQ-001 SHALL have parameter aw, default 32, address width in bits (byte address).
REQ-002 SHALL have parameter dw, default 32, data width in bits (four byte lanes).
REQ-003 SHALL have parameter DEPTH, default 1024, memory size in dw-bit words.
REQ-004 SHALL have parameter MEMFILE, default "", hex init file; empty string means no init.
REQ-005 SHALL have port wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port wb_adr_i  in  aw  byte address; word index = wb_adr_i[aw-1:2].
REQ-008 SHALL have port wb_dat_i  in  dw  write data.
REQ-009 SHALL have port wb_sel_i  in  4  byte-lane enables.
REQ-010 SHALL have ports wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  write enable, cycle, strobe.
REQ-011 SHALL have port wb_cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
REQ-012 SHALL have port wb_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-013 SHALL have port wb_sdt_o  out  dw  read data, valid while wb_ack_o=1.
REQ-014 SHALL have ports wb_ack_o, wb_err_o, wb_rty_o  out  1 each  acknowledge, error, retry.

Function
REQ-015 States: IDLE, BURST; beat = wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o in IDLE, wb_cyc_i & wb_stb_i in BURST.
REQ-016 IDLE beat with cti 000, 111 or reserved (011-110): ack one cycle later for exactly one cycle, stay IDLE (classic, 1 wait state).
REQ-017 IDLE beat with cti 001 or 010: ack next cycle, go BURST, register predicted next address.
REQ-018 BURST: ack asserted every cycle wb_stb_i=1 and wb_adr_i equals predicted address (zero-wait streaming).
REQ-019 BURST with wb_stb_i=0: ack=0 that cycle, prediction held, stay BURST.
REQ-020 BURST with wb_adr_i != prediction: ack=0 one cycle, treat as new IDLE-style beat (restart).
REQ-021 Prediction, cti 001: same word address.
REQ-022 Prediction, cti 010, bte 00: word address +1 modulo 2^(aw-2).
REQ-023 Prediction, cti 010, bte 01/10/11: low 2/3/4 word-address bits +1 modulo 4/8/16, upper bits unchanged.
REQ-024 Beat with cti 111 in BURST: ack it, next state IDLE, ack=0 following cycle.
REQ-025 wb_cyc_i=0 in any state: ack=0, err=0 next cycle, state IDLE; already-acked writes retained.
REQ-026 Write: on acked beat with wb_we_i=1, update only lanes with wb_sel_i[n]=1 at the edge asserting ack.
REQ-027 Read: wb_sdt_o = word at beat address, registered, aligned with ack; wb_sel_i ignored for reads.
REQ-028 Word index >= DEPTH: assert wb_err_o instead of ack for that beat, no write, state IDLE.
REQ-029 wb_ack_o and wb_err_o SHALL never be 1 together; wb_rty_o SHALL be constant 0.
REQ-030 wb_sdt_o SHALL be 0 whenever wb_ack_o=0.

Reset
REQ-031 wb_rst_i=0 at a rising edge: state IDLE, wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_sdt_o=0, prediction 0.
REQ-032 Reset mid-burst SHALL abort with no further ack and no write in the reset cycle; memory contents SHALL NOT be cleared.
REQ-033 MEMFILE load SHALL occur at time zero only, not on reset.

Structure
REQ-034 CTI and BTE encodings SHALL come from the shared wb_bfm_params constants, not be redefined locally.
REQ-035 Next-address computation SHALL be one sub-module, wb_burst_adr_gen (inputs: word address, cti, bte; output: next word address).
REQ-036 Memory array and lane-write logic SHALL stay in wb_burst_ram.

Verification
REQ-037 Classic write 0xDEADBEEF sel 1111 to 0x10, classic read 0x10 -> ack one cycle after stb, data 0xDEADBEEF.
REQ-038 Incrementing linear write of 8 words at 0x20, read back -> 8 consecutive acks, data in order.
REQ-039 Wrap-4 read starting at 0x38 -> addresses 0x38,0x3C,0x30,0x34, acked on consecutive cycles, data matching.
REQ-040 Write sel 0101 value 0x11223344 over 0xFFFFFFFF -> read 0xFF22FF44.
REQ-041 Burst at 0x20 with stb low for 2 cycles after beat 2, then cyc dropped after beat 4 -> no ack during gap, 4 words written, IDLE.
REQ-042 Read word index DEPTH -> err=1 one cycle, ack=0; reset asserted mid-burst -> ack=0 next edge, prior data intact.
